// File: rtl/dvp_pattern_tx_if.sv
// DVP camera bus: pixel clock, frame sync, line valid and pixel byte.
//   master : driven by the camera-side transmitter
//   slave  : observed by a capture block or testbench
interface dvp_pattern_tx_if;
  logic       cam_pclk;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_data;

  modport master (
    output cam_pclk,
    output cam_vsync,
    output cam_href,
    output cam_data
  );

  modport slave (
    input cam_pclk,
    input cam_vsync,
    input cam_href,
    input cam_data
  );
endinterface

// File: rtl/dvp_pattern_tx.sv
// Camera-side DVP transmitter emulating an OV5640 in RGB565 mode.
// Generates pclk = sys_clk/2, vsync, href and byte-serial RGB565 test
// patterns with programmable frame geometry.
//
// Ports:
//   sys_clk      : single clock, rising edge
//   sys_rst      : synchronous active-high reset
//   enable       : stream frames while high (checked at frame boundaries)
//   pattern_sel  : 0 bars, 1 ramp, 2 solid, 3 checkerboard
//   solid_color  : RGB565 value for the solid pattern
//   dvp          : camera bus (pclk, vsync, href, data), master side
//   frame_done   : one-cycle pulse on the last cycle of each frame
//   busy         : high while a frame is in progress
//   frame_cnt    : completed-frame counter, wraps at 16 bits
module dvp_pattern_tx #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned VS_LINES = 4,
  parameter int unsigned V_BACK   = 16,
  parameter int unsigned V_FRONT  = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    enable,
  input  logic [1:0]              pattern_sel,
  input  logic [15:0]             solid_color,
  dvp_pattern_tx_if.master        dvp,
  output logic                    frame_done,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HREF_SLOTS = 2 * H_ACTIVE;
  localparam int unsigned BAR_W      = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int unsigned H_W        = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
  localparam int unsigned MAX_A      = (VS_LINES > V_BACK)   ? VS_LINES : V_BACK;
  localparam int unsigned MAX_B      = (V_ACTIVE > V_FRONT)  ? V_ACTIVE : V_FRONT;
  localparam int unsigned MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned V_W        = $clog2(MAX_LINES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  function automatic int unsigned lines_of(state_t s);
    case (s)
      ST_VSYNC:  lines_of = VS_LINES;
      ST_VBACK:  lines_of = V_BACK;
      ST_ACTIVE: lines_of = V_ACTIVE;
      ST_VFRONT: lines_of = V_FRONT;
      default:   lines_of = 0;
    endcase
  endfunction

  function automatic state_t succ(state_t s, logic en);
    case (s)
      ST_IDLE:   succ = ST_VSYNC;
      ST_VSYNC:  succ = ST_VBACK;
      ST_VBACK:  succ = ST_ACTIVE;
      ST_ACTIVE: succ = ST_VFRONT;
      ST_VFRONT: succ = en ? ST_VSYNC : ST_IDLE;
      default:   succ = ST_IDLE;
    endcase
  endfunction

  // Next state after s, stepping over states configured with zero lines.
  function automatic state_t advance(state_t s, logic en);
    state_t n;
    logic   done;
    n    = s;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!done) begin
        n = succ(n, en);
        if (n == ST_IDLE || lines_of(n) != 0) done = 1'b1;
      end
    end
    advance = n;
  endfunction

  function automatic logic [15:0] pixel(logic [1:0] sel, logic [15:0] solid,
                                        logic [15:0] x, logic y5, logic f0);
    logic [2:0] bar;
    bar = 3'(x / 16'(BAR_W));
    case (sel)
      2'd0: begin
        case (bar)
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {x[4:0], x[5:0], x[4:0]};
      2'd2:    pixel = solid;
      default: pixel = (x[5] ^ y5 ^ f0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  logic             phase;
  state_t           state;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic [1:0]       pat_q;
  logic [15:0]      solid_q;
  logic             vsync_q;
  logic             href_q;
  logic [7:0]       data_q;

  state_t           ns;
  logic [H_W-1:0]   nh;
  logic [V_W-1:0]   nv;
  logic             last_h;
  logic             last_v;
  logic             frame_end;
  logic             latch;
  logic [1:0]       sel_eff;
  logic [15:0]      solid_eff;
  logic [15:0]      x;
  logic             y5;
  logic [15:0]      pix;
  logic             href_n;
  logic [7:0]       data_n;

  // Next-slot computation; state and counters describe the slot on the bus.
  always_comb begin
    last_h    = (32'(h_cnt) == LINE_SLOTS - 1);
    last_v    = (32'(v_cnt) == lines_of(state) - 1);
    // Frame ends on the last slot of the final non-empty state before wrap.
    frame_end = (state != ST_IDLE) && last_h && last_v &&
                (advance(state, 1'b0) == ST_IDLE);
    ns = state;
    nh = h_cnt;
    nv = v_cnt;
    if (state == ST_IDLE) begin
      if (enable) begin
        ns = advance(ST_IDLE, 1'b1);
        nh = '0;
        nv = '0;
      end
    end else if (last_h) begin
      nh = '0;
      if (last_v) begin
        ns = advance(state, enable);
        nv = '0;
      end else begin
        nv = v_cnt + V_W'(1);
      end
    end else begin
      nh = h_cnt + H_W'(1);
    end
    // A new frame starts here: pick up the controls in the same edge so
    // even a frame with no blank lines sees the new settings.
    latch     = ((state == ST_IDLE) || frame_end) && (ns != ST_IDLE);
    sel_eff   = latch ? pattern_sel : pat_q;
    solid_eff = latch ? solid_color : solid_q;
    x         = 16'(nh >> 1);
    y5        = 1'((32'(nv)) >> 5);
    pix       = pixel(sel_eff, solid_eff, x, y5, frame_cnt[0]);
    href_n    = (ns == ST_ACTIVE) && (32'(nh) < HREF_SLOTS);
    data_n    = 8'h00;
    if (href_n) data_n = nh[0] ? pix[7:0] : pix[15:8];
  end

  // Slot boundary: state and bus outputs update as phase returns to 0.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase      <= 1'b0;
      state      <= ST_IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pat_q      <= 2'd0;
      solid_q    <= 16'h0000;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      data_q     <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      phase      <= ~phase;
      frame_done <= 1'b0;
      if (!phase) begin
        // frame_done lands on the phase-1 cycle of the final slot.
        if (frame_end) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end
      end else begin
        state   <= ns;
        h_cnt   <= nh;
        v_cnt   <= nv;
        vsync_q <= (ns == ST_VSYNC);
        href_q  <= href_n;
        data_q  <= data_n;
        busy    <= (ns != ST_IDLE);
        if (latch) begin
          pat_q   <= pattern_sel;
          solid_q <= solid_color;
        end
      end
    end
  end

  assign dvp.cam_pclk  = phase;
  assign dvp.cam_vsync = vsync_q;
  assign dvp.cam_href  = href_q;
  assign dvp.cam_data  = data_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
module tb_dvp_pattern_tx;

  localparam int HA = 16, HB = 4, VA = 4, VS = 1, VBK = 1, VF = 1;
  localparam int LS = 2 * HA + HB;
  localparam int FRAME_CYC = 2 * LS * (VS + VBK + VA + VF);

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        frame_done;
  logic        busy;
  logic [15:0] frame_cnt;

  dvp_pattern_tx_if dvp ();

  dvp_pattern_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VS_LINES(VS), .V_BACK(VBK), .V_FRONT(VF)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .solid_color(solid_color),
    .dvp        (dvp),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int passed = 0;
  int total  = 0;
  logic [7:0] cap [0:VA-1][0:2*HA-1];

  typedef struct {
    int         pat;
    logic [15:0] solid;
    int         sph;
    int         x;
    int         y;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;
  vec_t tbl [8];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference pixel straight from the pattern definitions.
  function automatic logic [15:0] ref_pixel(int pat, logic [15:0] solid, int x, int y, logic [15:0] fc);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (pat)
      0: return bars[x / (HA / 8)];
      1: return 16'(((x & 31) << 11) | ((x & 63) << 5) | (x & 31));
      2: return solid;
      default: return ((((x >> 5) ^ (y >> 5) ^ int'(fc)) & 1) != 0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Waits for vsync, then checks every cycle of one frame against the model.
  // At frame cycle 100 the controls for the following frame are applied.
  task automatic check_frame(input int pat, input logic [15:0] solid, input logic [15:0] fc,
                             input int npat, input logic [15:0] nsolid, input logic nen,
                             output int waited);
    int errs, derr, cerr, s, ph, line, h, x, y;
    logic ev, eh;
    logic [7:0] ed;
    logic [15:0] pix;
    string first;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (dvp.cam_vsync !== 1'b1 && waited < 20);
    if (dvp.cam_vsync !== 1'b1) begin
      check("vsync_start_timeout", 32'(dvp.cam_vsync), 32'd1);
      return;
    end
    errs = 0; derr = 0; cerr = 0; first = "";
    for (int c = 1; c <= FRAME_CYC; c++) begin
      if (c > 1) tick();
      if (c == 100) begin
        pattern_sel = npat[1:0];
        solid_color = nsolid;
        enable = nen;
      end
      s = (c - 1) / 2; ph = (c - 1) % 2;
      line = s / LS; h = s % LS;
      ev = (line < VS);
      eh = (line >= VS + VBK) && (line < VS + VBK + VA) && (h < 2 * HA);
      y = line - VS - VBK; x = h / 2;
      ed = 8'h00;
      if (eh) begin
        pix = ref_pixel(pat, solid, x, y, fc);
        ed = (h % 2 == 0) ? pix[15:8] : pix[7:0];
      end
      if (dvp.cam_pclk !== ph[0] || dvp.cam_vsync !== ev || dvp.cam_href !== eh ||
          dvp.cam_data !== ed || busy !== 1'b1) begin
        if (errs == 0)
          first = $sformatf("cyc %0d pclk %b vs %b href %b data %h busy %b, want pclk %b vs %b href %b data %h busy 1",
                            c, dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, dvp.cam_data, busy, ph[0], ev, eh, ed);
        errs++;
      end
      if (eh && ph == 1) cap[y][h] = dvp.cam_data;
      if (frame_done !== (c == FRAME_CYC)) derr++;
      if (frame_cnt !== ((c < FRAME_CYC) ? fc : fc + 16'd1)) cerr++;
    end
    if (errs != 0) $display("FAIL frame_stream detail: %s", first);
    check("frame_stream_errors", 32'(errs), 32'd0);
    check("frame_done_position_errors", 32'(derr), 32'd0);
    check("frame_cnt_errors", 32'(cerr), 32'd0);
  endtask

  initial begin
    int w, bad, fc, cp, np;
    logic prev;
    logic [15:0] cs, nsv;

    tbl[0] = '{0, 16'h0000, 1,  0, 0, 8'hFF, 8'hFF};
    tbl[1] = '{0, 16'h0000, 0,  2, 1, 8'hFF, 8'hE0};
    tbl[2] = '{0, 16'h0000, 1,  4, 3, 8'h07, 8'hFF};
    tbl[3] = '{0, 16'h0000, 1, 15, 2, 8'h00, 8'h00};
    tbl[4] = '{1, 16'h0000, 0,  5, 0, 8'h28, 8'hA5};
    tbl[5] = '{1, 16'h0000, 1, 15, 3, 8'h79, 8'hEF};
    tbl[6] = '{2, 16'hA55A, 1,  9, 1, 8'hA5, 8'h5A};
    tbl[7] = '{3, 16'h0000, 1,  3, 0, 8'hFF, 8'hFF}; // seventh frame count is odd

    // Reset state
    tick(); tick(); tick();
    check("rst_pclk", 32'(dvp.cam_pclk), 32'd0);
    check("rst_outputs", {dvp.cam_vsync, dvp.cam_href, dvp.cam_data, frame_done, busy}, 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    sys_rst = 1'b0;

    // Idle with enable low: pclk runs, everything else quiet
    bad = 0;
    prev = dvp.cam_pclk;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dvp.cam_pclk === prev) bad++;
      prev = dvp.cam_pclk;
      if ({dvp.cam_vsync, dvp.cam_href, dvp.cam_data, busy} !== 11'd0 || frame_cnt !== 16'd0) bad++;
    end
    check("idle_quiet_errors", 32'(bad), 32'd0);

    // Table: one frame per entry from idle; pattern switched to 3 and enable
    // dropped mid-frame, so each frame must finish with its own pattern.
    fc = 0;
    for (int i = 0; i < 8; i++) begin
      pattern_sel = tbl[i].pat[1:0];
      solid_color = tbl[i].solid;
      w = 0;
      while (dvp.cam_pclk !== tbl[i].sph[0] && w < 4) begin tick(); w++; end
      enable = 1'b1;
      check_frame(tbl[i].pat, tbl[i].solid, 16'(fc), 3, 16'h1234, 1'b0, w);
      check($sformatf("start_latency_%0d", i), 32'(w), (tbl[i].sph == 1) ? 32'd1 : 32'd2);
      check($sformatf("byte_hi_%0d", i), 32'(cap[tbl[i].y][2 * tbl[i].x]), 32'(tbl[i].hi));
      check($sformatf("byte_lo_%0d", i), 32'(cap[tbl[i].y][2 * tbl[i].x + 1]), 32'(tbl[i].lo));
      fc++;
      tick();
      check($sformatf("busy_fall_%0d", i), {31'd0, busy} | {30'd0, dvp.cam_vsync, 1'b0}, 32'd0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (dvp.cam_vsync !== 1'b0 || busy !== 1'b0) bad++;
      end
      check($sformatf("no_restart_%0d", i), 32'(bad), 32'd0);
    end

    // Three back-to-back solid frames
    pattern_sel = 2'd2; solid_color = 16'hA55A; enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      check_frame(2, 16'hA55A, 16'(fc), 2, 16'hA55A, (f < 2), w);
      if (f > 0) check($sformatf("b2b_gap_%0d", f), 32'(w), 32'd1);
      fc++;
    end
    check("solid_frames_cnt", 32'(frame_cnt), 32'(fc));
    check("solid_byte_hi", 32'(cap[2][6]), 32'hA5);
    check("solid_byte_lo", 32'(cap[2][7]), 32'h5A);
    tick();

    // Randomized back-to-back frames, controls changed mid-frame
    cp = int'($urandom_range(0, 3)); cs = 16'($urandom);
    pattern_sel = cp[1:0]; solid_color = cs; enable = 1'b1;
    for (int r = 0; r < 5; r++) begin
      np = int'($urandom_range(0, 3)); nsv = 16'($urandom);
      check_frame(cp, cs, 16'(fc), np, nsv, (r < 4), w);
      if (r > 0) check($sformatf("rand_gap_%0d", r), 32'(w), 32'd1);
      fc++;
      cp = np; cs = nsv;
    end
    tick();

    // Reset in the middle of active line 2, then a clean frame
    pattern_sel = 2'd0; enable = 1'b1;
    w = 0;
    do begin tick(); w++; end while (dvp.cam_vsync !== 1'b1 && w < 20);
    check("rst_test_start", 32'(dvp.cam_vsync), 32'd1);
    for (int i = 0; i < 300; i++) tick();
    check("pre_rst_href", 32'(dvp.cam_href), 32'd1);
    sys_rst = 1'b1;
    tick();
    check("midrst_outputs", {dvp.cam_pclk, dvp.cam_vsync, dvp.cam_href, dvp.cam_data, frame_done, busy}, 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    sys_rst = 1'b0;
    check_frame(0, 16'h0000, 16'd0, 0, 16'h0000, 1'b0, w);
    check("post_rst_cnt", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
